// File: rtl/nab_axil_pkg.sv
// nab_axil_pkg
// Shared definitions for the bridge control/status register file:
//   - byte offsets of the decoded word registers
//   - AXI4-Lite response codes
//   - write/read channel FSM state encodings
//   - byte-lane merge helper used on register writes
package nab_axil_pkg;

   localparam logic [4:0] REG_CTRL     = 5'h00;
   localparam logic [4:0] REG_NET_OUT  = 5'h04;
   localparam logic [4:0] REG_PWM_DUTY = 5'h08;
   localparam logic [4:0] REG_XADC_MUX = 5'h0C;
   localparam logic [4:0] REG_AUX0     = 5'h10;
   localparam logic [4:0] REG_AUX1     = 5'h14;
   localparam logic [4:0] REG_AUX2     = 5'h18;
   localparam logic [4:0] REG_AUX3     = 5'h1C;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic {
      W_IDLE = 1'b0,
      W_RESP = 1'b1
   } w_state_t;

   typedef enum logic {
      R_IDLE = 1'b0,
      R_DATA = 1'b1
   } r_state_t;

   // Replace only the byte lanes that are enabled; with strobes disabled
   // every lane takes the new data.
   function automatic logic [31:0] apply_wstrb(
      input logic [31:0] old_word,
      input logic [31:0] new_word,
      input logic [3:0]  strb,
      input logic        use_strb
   );
      logic [31:0] merged;
      merged = old_word;
      for (int b = 0; b < 4; b++) begin
         if (!use_strb || strb[b]) begin
            merged[8*b +: 8] = new_word[8*b +: 8];
         end
      end
      return merged;
   endfunction

endpackage

// File: rtl/nab_axil_rd_mux.sv
// nab_axil_rd_mux
// Combinational read-data / read-response select for the register file.
// Ports:
//   rd_addr   - AXI byte read address; bits [1:0] are don't-care
//   ctrl      - CTRL register (bit 0 is always stored as 0)
//   net_out   - network output status word
//   pwm_duty  - PWM_DUTY register
//   xadc_mux  - XADC_MUX[3:0]
//   aux       - four aux status words, word k at aux[32k +: 32]
//   rdata     - selected word, 0 for out-of-range addresses
//   rresp     - OKAY inside the decoded range, SLVERR outside
module nab_axil_rd_mux
   import nab_axil_pkg::*;
#(
   parameter int ADDR_W   = 9,
   parameter int DATA_W   = 32,
   parameter int NUM_REGS = 8
) (
   input  logic [ADDR_W-1:0]   rd_addr,
   input  logic [DATA_W-1:0]   ctrl,
   input  logic [DATA_W-1:0]   net_out,
   input  logic [DATA_W-1:0]   pwm_duty,
   input  logic [3:0]          xadc_mux,
   input  logic [4*DATA_W-1:0] aux,
   output logic [DATA_W-1:0]   rdata,
   output logic [1:0]          rresp
);

   localparam int IDX_W = ADDR_W - 2;
   localparam logic [IDX_W-1:0] REG_LIMIT = IDX_W'(NUM_REGS);

   logic [IDX_W-1:0] word_idx;
   logic             in_range;
   logic [4:0]       word_off;
   logic             lsb_unused;

   assign word_idx   = rd_addr[ADDR_W-1:2];
   assign in_range   = (word_idx < REG_LIMIT);
   assign word_off   = {rd_addr[4:2], 2'b00};
   assign lsb_unused = ^rd_addr[1:0];

   always_comb begin
      rdata = '0;
      rresp = RESP_OKAY;
      if (!in_range) begin
         rresp = RESP_SLVERR;
      end else begin
         case (word_off)
            REG_CTRL:     rdata = ctrl;
            REG_NET_OUT:  rdata = net_out;
            REG_PWM_DUTY: rdata = pwm_duty;
            REG_XADC_MUX: rdata = {{(DATA_W-4){1'b0}}, xadc_mux};
            REG_AUX0:     rdata = aux[0*DATA_W +: DATA_W];
            REG_AUX1:     rdata = aux[1*DATA_W +: DATA_W];
            REG_AUX2:     rdata = aux[2*DATA_W +: DATA_W];
            REG_AUX3:     rdata = aux[3*DATA_W +: DATA_W];
            default:      rdata = '0;
         endcase
      end
   end

endmodule

// File: rtl/nab_axil_regfile.sv
// nab_axil_regfile
// AXI4-Lite responder holding the bridge control/status registers and
// driving the PWM / XADC control outputs.
// Ports:
//   S_AXI_*     - AXI4-Lite slave port (clock, active-low async reset,
//                 AW/W/B write channels, AR/R read channels)
//   net_out_i   - network output status, read at 0x04
//   aux_i       - aux status words, read at 0x10..0x1C
//   ctrl_o      - CTRL register contents (bit 0 always 0)
//   start_o     - one-cycle pulse after a write of CTRL[0]=1
//   pwm_duty_o  - PWM_DUTY register contents
//   xadc_mux_o  - XADC_MUX[3:0]
//
// Write FSM
//   state  | meaning
//   W_IDLE | waiting for AWVALID+WVALID; AWREADY/WREADY pulse, regs update
//   W_RESP | BVALID held with BRESP until BREADY
// Read FSM
//   state  | meaning
//   R_IDLE | waiting for ARVALID; ARREADY pulse, RDATA/RRESP captured
//   R_DATA | RVALID held with RDATA/RRESP until RREADY
module nab_axil_regfile
   import nab_axil_pkg::*;
#(
   parameter int ADDR_W    = 9,
   parameter int DATA_W    = 32,
   parameter int USE_WSTRB = 0,
   parameter int NUM_REGS  = 8
) (
   input  logic                  S_AXI_ACLK,
   input  logic                  S_AXI_ARESETN,
   input  logic [ADDR_W-1:0]     S_AXI_AWADDR,
   input  logic                  S_AXI_AWVALID,
   output logic                  S_AXI_AWREADY,
   input  logic [DATA_W-1:0]     S_AXI_WDATA,
   input  logic [DATA_W/8-1:0]   S_AXI_WSTRB,
   input  logic                  S_AXI_WVALID,
   output logic                  S_AXI_WREADY,
   output logic [1:0]            S_AXI_BRESP,
   output logic                  S_AXI_BVALID,
   input  logic                  S_AXI_BREADY,
   input  logic [ADDR_W-1:0]     S_AXI_ARADDR,
   input  logic                  S_AXI_ARVALID,
   output logic                  S_AXI_ARREADY,
   output logic [DATA_W-1:0]     S_AXI_RDATA,
   output logic [1:0]            S_AXI_RRESP,
   output logic                  S_AXI_RVALID,
   input  logic                  S_AXI_RREADY,
   input  logic [DATA_W-1:0]     net_out_i,
   input  logic [4*DATA_W-1:0]   aux_i,
   output logic [DATA_W-1:0]     ctrl_o,
   output logic                  start_o,
   output logic [DATA_W-1:0]     pwm_duty_o,
   output logic [3:0]            xadc_mux_o
);

   localparam int IDX_W = ADDR_W - 2;
   localparam logic [IDX_W-1:0] REG_LIMIT = IDX_W'(NUM_REGS);
   localparam logic USE_STRB = (USE_WSTRB != 0);

   w_state_t          w_state;
   r_state_t          r_state;

   logic              awready_q;
   logic              wready_q;
   logic              bvalid_q;
   logic [1:0]        bresp_q;
   logic              arready_q;
   logic              rvalid_q;
   logic [DATA_W-1:0] rdata_q;
   logic [1:0]        rresp_q;

   logic [DATA_W-1:0] ctrl_q;
   logic [DATA_W-1:0] pwm_q;
   logic [3:0]        xadc_q;
   logic              start_q;

   logic              wr_both_valid;
   logic              wr_in_range;
   logic [4:0]        wr_off;
   logic              wr_lane0;
   logic              awaddr_unused;

   logic [DATA_W-1:0] mux_rdata;
   logic [1:0]        mux_rresp;

   assign wr_both_valid = S_AXI_AWVALID && S_AXI_WVALID;
   assign wr_in_range   = (S_AXI_AWADDR[ADDR_W-1:2] < REG_LIMIT);
   assign wr_off        = {S_AXI_AWADDR[4:2], 2'b00};
   assign wr_lane0      = !USE_STRB || S_AXI_WSTRB[0];
   assign awaddr_unused = ^S_AXI_AWADDR[1:0];

   nab_axil_rd_mux #(
      .ADDR_W   (ADDR_W),
      .DATA_W   (DATA_W),
      .NUM_REGS (NUM_REGS)
   ) u_rd_mux (
      .rd_addr  (S_AXI_ARADDR),
      .ctrl     (ctrl_q),
      .net_out  (net_out_i),
      .pwm_duty (pwm_q),
      .xadc_mux (xadc_q),
      .aux      (aux_i),
      .rdata    (mux_rdata),
      .rresp    (mux_rresp)
   );

   // Write channel and register updates. READY is registered, so the
   // handshake edge is the one where AWREADY/WREADY are already high and
   // both valids are still present; registers take the data on that edge.
   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         w_state   <= W_IDLE;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         bresp_q   <= RESP_OKAY;
         ctrl_q    <= '0;
         pwm_q     <= '0;
         xadc_q    <= '0;
         start_q   <= 1'b0;
      end else begin
         start_q <= 1'b0;
         case (w_state)
            W_IDLE: begin
               if (awready_q) begin
                  awready_q <= 1'b0;
                  wready_q  <= 1'b0;
                  if (wr_both_valid) begin
                     w_state  <= W_RESP;
                     bvalid_q <= 1'b1;
                     if (wr_in_range) begin
                        bresp_q <= RESP_OKAY;
                        case (wr_off)
                           REG_CTRL: begin
                              // bit 0 is a strobe only, never stored
                              ctrl_q  <= apply_wstrb(ctrl_q, S_AXI_WDATA, S_AXI_WSTRB, USE_STRB)
                                         & ~32'h1;
                              start_q <= S_AXI_WDATA[0] && wr_lane0;
                           end
                           REG_PWM_DUTY: begin
                              pwm_q <= apply_wstrb(pwm_q, S_AXI_WDATA, S_AXI_WSTRB, USE_STRB);
                           end
                           REG_XADC_MUX: begin
                              if (wr_lane0) begin
                                 xadc_q <= S_AXI_WDATA[3:0];
                              end
                           end
                           default: ;
                        endcase
                     end else begin
                        bresp_q <= RESP_SLVERR;
                     end
                  end
               end else if (wr_both_valid) begin
                  awready_q <= 1'b1;
                  wready_q  <= 1'b1;
               end
            end
            W_RESP: begin
               if (S_AXI_BREADY) begin
                  bvalid_q <= 1'b0;
                  bresp_q  <= RESP_OKAY;
                  w_state  <= W_IDLE;
               end
            end
            default: w_state <= W_IDLE;
         endcase
      end
   end

   // Read channel. Data is captured from the mux on the handshake edge, so a
   // write landing on the same edge is not yet visible to this read.
   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         r_state   <= R_IDLE;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
         rresp_q   <= RESP_OKAY;
      end else begin
         case (r_state)
            R_IDLE: begin
               if (arready_q) begin
                  arready_q <= 1'b0;
                  if (S_AXI_ARVALID) begin
                     rvalid_q <= 1'b1;
                     rdata_q  <= mux_rdata;
                     rresp_q  <= mux_rresp;
                     r_state  <= R_DATA;
                  end
               end else if (S_AXI_ARVALID) begin
                  arready_q <= 1'b1;
               end
            end
            R_DATA: begin
               if (S_AXI_RREADY) begin
                  rvalid_q <= 1'b0;
                  r_state  <= R_IDLE;
               end
            end
            default: r_state <= R_IDLE;
         endcase
      end
   end

   assign S_AXI_AWREADY = awready_q;
   assign S_AXI_WREADY  = wready_q;
   assign S_AXI_BVALID  = bvalid_q;
   assign S_AXI_BRESP   = bresp_q;
   assign S_AXI_ARREADY = arready_q;
   assign S_AXI_RVALID  = rvalid_q;
   assign S_AXI_RDATA   = rdata_q;
   assign S_AXI_RRESP   = rresp_q;

   assign ctrl_o     = ctrl_q;
   assign start_o    = start_q;
   assign pwm_duty_o = pwm_q;
   assign xadc_mux_o = xadc_q;

endmodule

// File: tb/tb_nab_axil_regfile.sv
// Bench for nab_axil_regfile. Two instances share one AXI stimulus stream:
// dut0 ignores WSTRB, dut1 honours it. A reference model tracks both.
module tb_nab_axil_regfile;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst_n;
   logic [8:0]   awaddr, araddr;
   logic         awvalid, wvalid, bready, arvalid, rready;
   logic [31:0]  wdata;
   logic [3:0]   wstrb;
   logic [31:0]  net_out;
   logic [127:0] aux;

   logic         awready [2];
   logic         wready  [2];
   logic         bvalid  [2];
   logic         arready [2];
   logic         rvalid  [2];
   logic         start   [2];
   logic [1:0]   bresp   [2];
   logic [1:0]   rresp   [2];
   logic [31:0]  rdata   [2];
   logic [31:0]  ctrl    [2];
   logic [31:0]  pwm     [2];
   logic [3:0]   xadc    [2];

   nab_axil_regfile #(.ADDR_W(9), .DATA_W(32), .USE_WSTRB(0), .NUM_REGS(8)) dut0 (
      .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
      .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready[0]),
      .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready[0]),
      .S_AXI_BRESP(bresp[0]), .S_AXI_BVALID(bvalid[0]), .S_AXI_BREADY(bready),
      .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready[0]),
      .S_AXI_RDATA(rdata[0]), .S_AXI_RRESP(rresp[0]), .S_AXI_RVALID(rvalid[0]), .S_AXI_RREADY(rready),
      .net_out_i(net_out), .aux_i(aux), .ctrl_o(ctrl[0]), .start_o(start[0]),
      .pwm_duty_o(pwm[0]), .xadc_mux_o(xadc[0]));

   nab_axil_regfile #(.ADDR_W(9), .DATA_W(32), .USE_WSTRB(1), .NUM_REGS(8)) dut1 (
      .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
      .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready[1]),
      .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready[1]),
      .S_AXI_BRESP(bresp[1]), .S_AXI_BVALID(bvalid[1]), .S_AXI_BREADY(bready),
      .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready[1]),
      .S_AXI_RDATA(rdata[1]), .S_AXI_RRESP(rresp[1]), .S_AXI_RVALID(rvalid[1]), .S_AXI_RREADY(rready),
      .net_out_i(net_out), .aux_i(aux), .ctrl_o(ctrl[1]), .start_o(start[1]),
      .pwm_duty_o(pwm[1]), .xadc_mux_o(xadc[1]));

   int n_cmp  = 0;
   int n_fail = 0;

   // start_o pulse counters: seen on the DUT vs expected from the model
   int start_seen [2] = '{0, 0};
   int start_exp  [2] = '{0, 0};
   always @(negedge clk) begin
      if (start[0] === 1'b1) start_seen[0]++;
      if (start[1] === 1'b1) start_seen[1]++;
   end

   // reference model
   logic [31:0] m_ctrl [2];
   logic [31:0] m_pwm  [2];
   logic [3:0]  m_xadc [2];

   typedef struct packed {
      logic [31:0] d0;
      logic [31:0] d1;
      logic [1:0]  r0;
      logic [1:0]  r1;
   } rd_exp_t;

   rd_exp_t    rd_q [$];
   logic [1:0] wr_q [$];

   function automatic logic [31:0] lane_merge(input logic [31:0] o, input logic [31:0] n,
                                              input logic [3:0] s, input bit use_s);
      logic [31:0] r;
      r = o;
      for (int b = 0; b < 4; b++)
         if (!use_s || s[b]) r[8*b +: 8] = n[8*b +: 8];
      return r;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_ctrl[i] = '0;
         m_pwm[i]  = '0;
         m_xadc[i] = '0;
      end
   endtask

   task automatic model_write(input logic [8:0] addr, input logic [31:0] data,
                              input logic [3:0] strb, output logic [1:0] resp);
      resp = 2'b00;
      if (addr >= 9'h020) begin
         resp = 2'b10;
         return;
      end
      for (int i = 0; i < 2; i++) begin
         bit use_s;
         use_s = (i == 1);
         case (addr[4:2])
            3'd0: begin
               m_ctrl[i] = lane_merge(m_ctrl[i], data, strb, use_s) & 32'hFFFF_FFFE;
               if (data[0] && (!use_s || strb[0])) start_exp[i]++;
            end
            3'd2: m_pwm[i] = lane_merge(m_pwm[i], data, strb, use_s);
            3'd3: if (!use_s || strb[0]) m_xadc[i] = data[3:0];
            default: ;
         endcase
      end
   endtask

   function automatic logic [33:0] model_read(input int i, input logic [8:0] addr);
      if (addr >= 9'h020) return {2'b10, 32'h0};
      case (addr[4:2])
         3'd0: return {2'b00, m_ctrl[i]};
         3'd1: return {2'b00, net_out};
         3'd2: return {2'b00, m_pwm[i]};
         3'd3: return {2'b00, 28'h0, m_xadc[i]};
         3'd4: return {2'b00, aux[31:0]};
         3'd5: return {2'b00, aux[63:32]};
         3'd6: return {2'b00, aux[95:64]};
         default: return {2'b00, aux[127:96]};
      endcase
   endfunction

   function automatic rd_exp_t make_rd_exp(input logic [8:0] addr);
      rd_exp_t e;
      logic [33:0] a, b;
      a = model_read(0, addr);
      b = model_read(1, addr);
      e.d0 = a[31:0];
      e.d1 = b[31:0];
      e.r0 = a[33:32];
      e.r1 = b[33:32];
      return e;
   endfunction

   task automatic axi_write(input logic [8:0] addr, input logic [31:0] data, input logic [3:0] strb);
      logic [1:0] er;
      int n;
      logic hs;
      model_write(addr, data, strb, er);
      wr_q.push_back(er);
      awaddr = addr; wdata = data; wstrb = strb;
      awvalid = 1'b1; wvalid = 1'b1;
      n = 0;
      while (!bvalid[0] && n < 20) begin
         @(negedge clk); hs = awready[0] && wready[0];
         @(posedge clk); #1; n++;
         if (hs) begin awvalid = 1'b0; wvalid = 1'b0; end
      end
      awvalid = 1'b0; wvalid = 1'b0;
      er = wr_q.pop_front();
      n_cmp++;
      if (n !== 2) begin
         n_fail++;
         $display("FAIL wr_latency addr=%h got %0d cycles exp 2", addr, n);
      end
      n_cmp++;
      if (bresp[0] !== er || bresp[1] !== er || bvalid[1] !== 1'b1) begin
         n_fail++;
         $display("FAIL bresp addr=%h got %b/%b exp %b", addr, bresp[0], bresp[1], er);
      end
      @(posedge clk); #1;
   endtask

   task automatic axi_read(input logic [8:0] addr);
      rd_exp_t e;
      int n;
      logic hs;
      rd_q.push_back(make_rd_exp(addr));
      araddr = addr; arvalid = 1'b1;
      n = 0;
      while (!rvalid[0] && n < 20) begin
         @(negedge clk); hs = arready[0];
         @(posedge clk); #1; n++;
         if (hs) arvalid = 1'b0;
      end
      arvalid = 1'b0;
      e = rd_q.pop_front();
      n_cmp++;
      if (n !== 2) begin
         n_fail++;
         $display("FAIL rd_latency addr=%h got %0d cycles exp 2", addr, n);
      end
      n_cmp++;
      if (rdata[0] !== e.d0 || rresp[0] !== e.r0) begin
         n_fail++;
         $display("FAIL rd_dut0 addr=%h got %h/%b exp %h/%b", addr, rdata[0], rresp[0], e.d0, e.r0);
      end
      n_cmp++;
      if (rdata[1] !== e.d1 || rresp[1] !== e.r1) begin
         n_fail++;
         $display("FAIL rd_dut1 addr=%h got %h/%b exp %h/%b", addr, rdata[1], rresp[1], e.d1, e.r1);
      end
      @(posedge clk); #1;
   endtask

   task automatic check_starts(input string tag);
      for (int i = 0; i < 2; i++) begin
         n_cmp++;
         if (start_seen[i] !== start_exp[i]) begin
            n_fail++;
            $display("FAIL start_count_%s dut%0d got %0d exp %0d", tag, i, start_seen[i], start_exp[i]);
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      awvalid = 0; wvalid = 0; arvalid = 0; bready = 1; rready = 1;
      awaddr = 0; araddr = 0; wdata = 0; wstrb = 0;
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
         n_cmp++;
         if ({awready[i], wready[i], bvalid[i], arready[i], rvalid[i], start[i]} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_handshake dut%0d got %b exp 000000", i,
                     {awready[i], wready[i], bvalid[i], arready[i], rvalid[i], start[i]});
         end
         n_cmp++;
         if ({bresp[i], rresp[i], rdata[i]} !== 36'h0) begin
            n_fail++;
            $display("FAIL reset_resp dut%0d got %b %b %h exp 0", i, bresp[i], rresp[i], rdata[i]);
         end
         n_cmp++;
         if ({ctrl[i], pwm[i], xadc[i]} !== 68'h0) begin
            n_fail++;
            $display("FAIL reset_regs dut%0d got %h %h %h exp 0", i, ctrl[i], pwm[i], xadc[i]);
         end
      end
      axi_read(9'h000);
      axi_read(9'h008);
      axi_read(9'h00C);
   endtask

   task automatic test_full_map();
      for (int a = 0; a < 8; a++) axi_write(9'(a * 4), 32'hDEAD_BEEF, 4'h0);
      n_cmp++;
      if (ctrl[0] !== 32'hDEAD_BEEE || pwm[0] !== 32'hDEAD_BEEF || xadc[0] !== 4'hF) begin
         n_fail++;
         $display("FAIL full_map_outputs got %h %h %h exp deadbeee deadbeef f", ctrl[0], pwm[0], xadc[0]);
      end
      n_cmp++;
      if (ctrl[1] !== 32'h0 || pwm[1] !== 32'h0) begin
         n_fail++;
         $display("FAIL strobe_zero_dut1 got %h %h exp 0 0", ctrl[1], pwm[1]);
      end
      n_cmp++;
      if (start_seen[0] !== 1) begin
         n_fail++;
         $display("FAIL single_start got %0d exp 1", start_seen[0]);
      end
      check_starts("full_map");
      for (int a = 0; a < 8; a++) axi_read(9'(a * 4));
      axi_read(9'h00B);  // low address bits are don't-care
   endtask

   task automatic test_out_of_range();
      axi_write(9'h040, 32'h1234_5678, 4'hF);
      n_cmp++;
      if (pwm[0] !== 32'hDEAD_BEEF) begin
         n_fail++;
         $display("FAIL oor_pwm_unchanged got %h exp deadbeef", pwm[0]);
      end
      axi_read(9'h1FC);
      axi_read(9'h020);
   endtask

   task automatic test_back_to_back();
      axi_write(9'h000, 32'h0000_0001, 4'hF);
      axi_write(9'h000, 32'h0000_0001, 4'hF);
      check_starts("b2b");
      net_out = 32'h5A5A_0F0F;
      axi_read(9'h004);
      net_out = 32'h0000_FFFF;
      axi_read(9'h004);
   endtask

   task automatic test_backpressure();
      rd_exp_t    e;
      logic [1:0] er;
      int         n;
      bready = 1'b0; rready = 1'b0;
      rd_q.push_back(make_rd_exp(9'h008));          // read sees pre-write value
      model_write(9'h008, 32'hCAFE_F00D, 4'hF, er);
      wr_q.push_back(er);
      awaddr = 9'h008; wdata = 32'hCAFE_F00D; wstrb = 4'hF; araddr = 9'h008;
      awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
      n = 0;
      while (!(bvalid[0] && rvalid[0]) && n < 20) begin
         @(posedge clk); #1; n++;
      end
      n_cmp++;
      if (n !== 2) begin
         n_fail++;
         $display("FAIL concurrent_latency got %0d exp 2", n);
      end
      e  = rd_q.pop_front();
      er = wr_q.pop_front();
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         n_cmp++;
         if (bvalid[0] !== 1'b1 || rvalid[0] !== 1'b1 || rdata[0] !== e.d0 ||
             bresp[0] !== er || awready[0] !== 1'b0 || arready[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_cycle%0d got bv=%b rv=%b rd=%h br=%b awr=%b arr=%b exp 1 1 %h %b 0 0",
                     k, bvalid[0], rvalid[0], rdata[0], bresp[0], awready[0], arready[0], e.d0, er);
         end
      end
      @(posedge clk); #1;
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      @(posedge clk); #1;
      bready = 1'b1; rready = 1'b1;
      @(posedge clk); #1;
      n_cmp++;
      if (bvalid[0] !== 1'b0 || rvalid[0] !== 1'b0 || pwm[0] !== 32'hCAFE_F00D) begin
         n_fail++;
         $display("FAIL release got bv=%b rv=%b pwm=%h exp 0 0 cafef00d", bvalid[0], rvalid[0], pwm[0]);
      end
      @(posedge clk); #1;
      axi_read(9'h008);
   endtask

   task automatic test_wstrb();
      axi_write(9'h008, 32'hDEAD_BEEF, 4'hF);
      axi_write(9'h008, 32'h1122_3344, 4'b0101);
      n_cmp++;
      if (pwm[1] !== 32'hDE22_BE44 || pwm[0] !== 32'h1122_3344) begin
         n_fail++;
         $display("FAIL wstrb_merge got %h/%h exp de22be44/11223344", pwm[1], pwm[0]);
      end
      axi_read(9'h008);
      axi_write(9'h000, 32'h0000_0101, 4'b1110);    // dut1 must not pulse
      axi_write(9'h00C, 32'h0000_0007, 4'b1110);
      check_starts("wstrb");
      axi_read(9'h000);
      axi_read(9'h00C);
   endtask

   task automatic test_reset_mid();
      int n;
      bready = 1'b0;
      awaddr = 9'h000; wdata = 32'h0000_0F00; wstrb = 4'hF;
      awvalid = 1'b1; wvalid = 1'b1;
      n = 0;
      while (!bvalid[0] && n < 20) begin
         @(posedge clk); #1; n++;
      end
      awvalid = 1'b0; wvalid = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (bvalid[0] !== 1'b1 || ctrl[0] !== 32'h0000_0F00) begin
         n_fail++;
         $display("FAIL pre_reset got bv=%b ctrl=%h exp 1 00000f00", bvalid[0], ctrl[0]);
      end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++;
      if (bvalid[0] !== 1'b0 || ctrl[0] !== 32'h0 || bvalid[1] !== 1'b0) begin
         n_fail++;
         $display("FAIL async_reset got bv=%b ctrl=%h exp 0 0", bvalid[0], ctrl[0]);
      end
      model_reset();
      bready = 1'b1;
      @(posedge clk);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      axi_write(9'h008, 32'h0BAD_F00D, 4'hF);
      axi_read(9'h008);
      axi_read(9'h000);
   endtask

   initial begin
      net_out = 32'hA5A5_0001;
      aux = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
      test_reset();
      test_full_map();
      test_out_of_range();
      test_back_to_back();
      test_backpressure();
      test_wstrb();
      test_reset_mid();
      n_cmp++;
      if (rd_q.size() != 0 || wr_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain got %0d/%0d left exp 0/0", rd_q.size(), wr_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/nab_axil_regfile.md
Name: nab_axil_regfile

Overview:
AXI4-Lite responder (slave) holding the bridge's control/status register file, on the same S_AXI_* bus that the host and testbench drive as initiator. It decodes 32-bit word accesses at byte addresses 0x00–0x1C and drives the control outputs for the PWM and XADC logic. It also presents the network output and aux status words for readback. The block sits directly under neuromorphic_asic_bridge_top, between the AXI port and the core/PWM/XADC logic.

Parameters:
ADDR_W, 9, AXI address width (byte addresses)
DATA_W, 32, AXI data width; the only supported value is 32
USE_WSTRB, 0, 0 = ignore S_AXI_WSTRB and write the full word; 1 = byte-lane enables apply
NUM_REGS, 8, number of decoded word registers; the decoded range is 0 to 4*NUM_REGS-1

Ports:
S_AXI_ACLK  in  1  clock
S_AXI_ARESETN  in  1  asynchronous active-low reset
S_AXI_AWADDR  in  9  write address
S_AXI_AWVALID  in  1  write address valid
S_AXI_AWREADY  out  1  write address accept
S_AXI_WDATA  in  32  write data
S_AXI_WSTRB  in  4  byte strobes
S_AXI_WVALID  in  1  write data valid
S_AXI_WREADY  out  1  write data accept
S_AXI_BRESP  out  2  write response
S_AXI_BVALID  out  1  write response valid
S_AXI_BREADY  in  1  write response ready
S_AXI_ARADDR  in  9  read address
S_AXI_ARVALID  in  1  read address valid
S_AXI_ARREADY  out  1  read address accept
S_AXI_RDATA  out  32  read data
S_AXI_RRESP  out  2  read response
S_AXI_RVALID  out  1  read data valid
S_AXI_RREADY  in  1  read data ready
net_out_i  in  32  network output status (register 0x04)
aux_i  in  128  aux status words; aux_i[32k+31:32k] maps to 0x10+4k
ctrl_o  out  32  CTRL register contents
start_o  out  1  one-cycle pulse on a write of CTRL[0]=1
pwm_duty_o  out  32  PWM_DUTY register contents
xadc_mux_o  out  4  XADC_MUX[3:0]

Behaviour:
- Reset: all outputs are 0. This includes READY, VALID, RESP, RDATA, CTRL, PWM_DUTY, XADC_MUX and start_o. The write FSM returns to W_IDLE and the read FSM to R_IDLE immediately, even mid-transaction. A pending BVALID or RVALID is dropped.
- Register map (word offset, access, meaning):
  - 0x00 CTRL, RW. Bit 0 is self-clearing: it reads back 0 and its write pulses start_o.
  - 0x04 NET_OUT, RO, returns net_out_i.
  - 0x08 PWM_DUTY, RW.
  - 0x0C XADC_MUX, RW, bits [3:0] only; upper bits read 0.
  - 0x10–0x1C AUX0–3, RO, return aux_i.
- Address decode uses AWADDR[4:2] and ARADDR[4:2]. AWADDR[1:0] and ARADDR[1:0] are ignored.
- Out-of-range addresses: any address >= 0x20 returns resp 2'b10 (SLVERR). Writes to it have no effect; reads return 0.
- Writes to RO registers: OKAY response, no effect.
- Write FSM:
  - W_IDLE: when AWVALID and WVALID are both 1, assert AWREADY and WREADY together for exactly one cycle. The register update happens on that same edge.
  - Then move to W_RESP. BVALID rises 1 cycle after the accept cycle and is held with BRESP stable until BREADY=1, then return to W_IDLE.
  - AWVALID without WVALID (or the reverse) is not accepted. No new write is accepted while in W_RESP.
- WSTRB: with USE_WSTRB=1, byte lane b is written only when WSTRB[b]=1. A CTRL[0] pulse requires WSTRB[0]=1. With USE_WSTRB=0 the whole word is always written.
- Read FSM:
  - R_IDLE: when ARVALID=1, pulse ARREADY for one cycle and capture RDATA/RRESP on that edge.
  - R_DATA: RVALID=1 from the next cycle, with RDATA held stable until RREADY=1, then return to R_IDLE.
  - Read latency is 2 cycles from ARVALID to RVALID.
- Simultaneous read and write to the same register on the same edge: the read returns the pre-write value.
- start_o is high for exactly one cycle, on the cycle after the write accept. Back-to-back CTRL[0] writes give one pulse each.
- Read and write channels are independent and may be in progress concurrently.

Decomposition:
- Package nab_axil_pkg holds:
  - register offset constants REG_CTRL…REG_AUX3;
  - RESP_OKAY=2'b00 and RESP_SLVERR=2'b10;
  - FSM state encodings for W_IDLE/W_RESP and R_IDLE/R_DATA.
- One natural sub-module, nab_axil_rd_mux: the combinational read-data/response select, indexed by word address.

Test Plan:
- Reset held, then released → all outputs 0. Then read 0x00, 0x08, 0x0C → 0x00000000 with OKAY.
- Write 0xDEADBEEF to 0x00–0x1C with WSTRB=0, then read back:
  - 0x00 → 0xDEADBEEE, with a single start_o pulse;
  - 0x08 → 0xDEADBEEF;
  - 0x0C → 0x0000000F and xadc_mux_o=4'hF;
  - 0x04 → net_out_i; 0x10–0x1C → the matching aux_i words.
- Write 0x40 then read 0x1FC → BRESP=2'b10, RRESP=2'b10, RDATA=0; PWM_DUTY unchanged.
- Hold BREADY=0 and RREADY=0 for 5 cycles → BVALID, RVALID and RDATA stay stable; no second AWREADY or ARREADY while held.
- USE_WSTRB=1: write 0x11223344 to 0x08 with WSTRB=4'b0101 over 0xDEADBEEF → reads 0xDE22BE44.
- Drop ARESETN while BVALID=1 → BVALID=0 asynchronously and ctrl_o=0; the next write completes normally.
